i2c_nco_cfg_slave: RTL and testbench

- Multi-channel I2C configuration slave for the NCO array. Successor to the single-channel control/frequency/duty slave.
- Adds a byte-addressed register map with auto-incrementing pointer, NUM_CH channels, parametrised frequency/duty widths and shadowed writes committed atomically at STOP.
- Adds optional register readback.
- Sits between the board I2C pads and the per-channel NCO cores.

---
 rtl/i2c_nco_cfg_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_i2c_nco_cfg_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_nco_cfg_slave.sv
// I2C register slave for a multi-channel NCO array; shadow writes are committed atomically at STOP; `ifdef I2C_NCO_READBACK_EN adds register reads.
// Latency: SCL/SDA are seen 3 clk late (2-FF sync + edge stage); active outputs and the update pulse follow STOP by 1 clk.
// Backpressure: none on the NCO side; the I2C master is never clock-stretched, and bytes are always ACKed once the slave is addressed.
`timescale 1ns/1ps
module i2c_nco_cfg_slave #(
    parameter logic [6:0] ADDRESS = 7'h6A,
    parameter int         NUM_CH  = 2,
    parameter int         FREQ_W  = 64,
    parameter int         DUTY_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scl,
    input  logic                       sda_i,
    output logic                       sda_oe,
    output logic [NUM_CH-1:0]          enable,
    output logic [2*NUM_CH-1:0]        wave,
    output logic [FREQ_W*NUM_CH-1:0]   frequency,
    output logic [DUTY_W*NUM_CH-1:0]   duty_cycle,
    output logic [NUM_CH-1:0]          update,
    output logic                       busy
);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] ADDR       = 4'd1;
    localparam logic [3:0] ADDR_ACK   = 4'd2;
    localparam logic [3:0] PTR        = 4'd3;
    localparam logic [3:0] PTR_ACK    = 4'd4;
    localparam logic [3:0] WDATA      = 4'd5;
    localparam logic [3:0] WDATA_ACK  = 4'd6;
    localparam logic [3:0] RDATA      = 4'd7;
    localparam logic [3:0] RDATA_MACK = 4'd8;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] byte_in;
    logic [7:0] ptr;
    logic       wr_en;

    logic [2:0]        sh_ctrl  [NUM_CH];
    logic [FREQ_W-1:0] sh_freq  [NUM_CH];
    logic [DUTY_W-1:0] sh_duty  [NUM_CH];
    logic [2:0]        act_ctrl [NUM_CH];
    logic [FREQ_W-1:0] act_freq [NUM_CH];
    logic [DUTY_W-1:0] act_duty [NUM_CH];
    logic [NUM_CH-1:0] dirty;

`ifdef I2C_NCO_READBACK_EN
    logic       rw;
    logic       mack;
    logic [7:0] tx;
    logic [7:0] rd_byte;
`endif

    // Reset to the idle-bus level so leaving reset cannot fake a START/STOP edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in   = {shreg, sda_s};

    // The last bit of a data byte lands on a rising SCL, which can never coincide with START/STOP.
    assign wr_en = (state == WDATA) && scl_rise && (bit_cnt == 4'd7);

`ifdef I2C_NCO_READBACK_EN
    always_comb begin
        rd_byte = 8'h00;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(ptr[7:4]) == c) begin
                if (ptr[3:0] == 4'd0)
                    rd_byte = {5'd0, act_ctrl[c]};
                for (int b = 0; b < FREQ_W; b++)
                    if (int'(ptr[3:0]) == 8 - b / 8)
                        rd_byte[b % 8] = act_freq[c][b];
                for (int b = 0; b < DUTY_W; b++)
                    if (int'(ptr[3:0]) == 10 - b / 8)
                        rd_byte[b % 8] = act_duty[c][b];
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shreg   <= 7'd0;
            ptr     <= 8'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
`ifdef I2C_NCO_READBACK_EN
            rw      <= 1'b0;
            mack    <= 1'b0;
            tx      <= 8'd0;
`endif
        end else if (start_det) begin
            state   <= ADDR;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
        end else if (stop_det) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (scl_rise)
                shreg <= byte_in[6:0];
            case (state)
                ADDR: if (scl_rise) begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        if (byte_in[7:1] == ADDRESS) begin
`ifdef I2C_NCO_READBACK_EN
                            rw    <= byte_in[0];
                            state <= ADDR_ACK;
                            busy  <= 1'b1;
`else
                            if (!byte_in[0]) begin
                                state <= ADDR_ACK;
                                busy  <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                // First falling edge drives ACK, the second (end of 9th clock) releases it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe <= 1'b1;
                    end else begin
                        sda_oe  <= 1'b0;
                        bit_cnt <= 4'd0;
                        if (state == ADDR_ACK) begin
`ifdef I2C_NCO_READBACK_EN
                            if (rw) begin
                                state  <= RDATA;
                                tx     <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                            end else begin
                                state <= PTR;
                            end
`else
                            state <= PTR;
`endif
                        end else begin
                            state <= WDATA;
                        end
                    end
                end
                PTR: if (scl_rise) begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        ptr     <= byte_in;
                        state   <= PTR_ACK;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                WDATA: if (scl_rise) begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt <= 4'd0;
                        ptr     <= ptr + 8'd1;
                        state   <= WDATA_ACK;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
`ifdef I2C_NCO_READBACK_EN
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            mack    <= 1'b0;
                            state   <= RDATA_MACK;
                        end else begin
                            tx     <= {tx[6:0], 1'b0};
                            sda_oe <= ~tx[6];
                        end
                    end
                end
                RDATA_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            mack <= 1'b1;
                            ptr  <= ptr + 8'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (scl_fall && mack) begin
                        mack    <= 1'b0;
                        bit_cnt <= 4'd0;
                        tx      <= rd_byte;
                        sda_oe  <= ~rd_byte[7];
                        state   <= RDATA;
                    end
                end
`else
                RDATA, RDATA_MACK: begin
                    state  <= IDLE;
                    sda_oe <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end

    // Shadow and active register banks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty  <= '0;
            update <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sh_ctrl[c]  <= 3'd0;
                sh_freq[c]  <= '0;
                sh_duty[c]  <= '0;
                act_ctrl[c] <= 3'd0;
                act_freq[c] <= '0;
                act_duty[c] <= '0;
            end
        end else begin
            update <= '0;
            if (stop_det) begin
                update <= dirty;
                dirty  <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (dirty[c]) begin
                        act_ctrl[c] <= sh_ctrl[c];
                        act_freq[c] <= sh_freq[c];
                        act_duty[c] <= sh_duty[c];
                    end
                end
            end else if (wr_en) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (int'(ptr[7:4]) == c) begin
                        dirty[c] <= 1'b1;
                        if (ptr[3:0] == 4'd0)
                            sh_ctrl[c] <= byte_in[2:0];
                        for (int b = 0; b < FREQ_W; b++)
                            if (int'(ptr[3:0]) == 8 - b / 8)
                                sh_freq[c][b] <= byte_in[b % 8];
                        for (int b = 0; b < DUTY_W; b++)
                            if (int'(ptr[3:0]) == 10 - b / 8)
                                sh_duty[c][b] <= byte_in[b % 8];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign enable[c]                          = act_ctrl[c][0];
        assign wave[2*c +: 2]                     = act_ctrl[c][2:1];
        assign frequency[c*FREQ_W +: FREQ_W]      = act_freq[c];
        assign duty_cycle[c*DUTY_W +: DUTY_W]     = act_duty[c];
    end

endmodule

// File: tb/tb_i2c_nco_cfg_slave.sv
// Directed bench for i2c_nco_cfg_slave: bit-banged I2C master on an open-drain SDA line.
`timescale 1ns/1ps
module tb_i2c_nco_cfg_slave;

    localparam time Q = 100ns;

    logic         clk = 1'b0;
    logic         reset;
    logic         scl;
    logic         sda_m;
    logic         sda_i;
    logic         sda_oe;
    logic [1:0]   enable;
    logic [3:0]   wave;
    logic [127:0] frequency;
    logic [31:0]  duty_cycle;
    logic [1:0]   update;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic       clr_mon = 1'b0;
    int         upd_cnt;
    logic [1:0] upd_or;
    logic       oe_seen, busy_seen;

    logic       ack;
    logic [7:0] rd;

    always #5 clk = ~clk;

    assign sda_i = sda_m & ~sda_oe;

    i2c_nco_cfg_slave dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda_i      (sda_i),
        .sda_oe     (sda_oe),
        .enable     (enable),
        .wave       (wave),
        .frequency  (frequency),
        .duty_cycle (duty_cycle),
        .update     (update),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (clr_mon) begin
            upd_cnt   <= 0;
            upd_or    <= 2'b00;
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (update != 2'b00) begin
                upd_cnt <= upd_cnt + 1;
                upd_or  <= upd_or | update;
            end
            if (sda_oe) oe_seen <= 1'b1;
            if (busy) busy_seen <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr_mon = 1'b0;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; #Q;
            scl = 1'b1; #(2*Q);
            scl = 1'b0; #Q;
        end
        sda_m = 1'b1; #Q;
        scl = 1'b1; #Q;
        a = sda_i; #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic wr(input logic [7:0] d, input string tag);
        logic a;
        send_byte(d, a);
        check(tag, a, 1'b0);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        sda_m = 1'b1;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            #Q; scl = 1'b1;
            #Q; d = {d[6:0], sda_i};
            #Q; scl = 1'b0;
            #Q;
        end
        sda_m = nack; #Q;
        scl = 1'b1; #(2*Q);
        scl = 1'b0; #Q;
        sda_m = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_update", update, 2'b00);
        check("rst_enable", enable, 2'b00);
        check("rst_wave", wave, 4'h0);
        check("rst_freq", frequency, 128'h0);
        check("rst_duty", duty_cycle, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Control write to channel 0, visible only after STOP.
        clear_mon();
        i2c_start();
        wr(8'hD4, "t1_addr_ack");
        check("t1_busy", busy, 1'b1);
        wr(8'h00, "t1_ptr_ack");
        wr(8'h05, "t1_data_ack");
        check("t1_enable_pre_stop", enable, 2'b00);
        check("t1_no_update_pre_stop", upd_cnt, 0);
        i2c_stop();
        check("t1_enable", enable, 2'b01);
        check("t1_wave", wave, 4'b0010);
        check("t1_update_cycles", upd_cnt, 1);
        check("t1_update_val", upd_or, 2'b01);
        check("t1_busy_after_stop", busy, 1'b0);

        // Full 64-bit frequency write to channel 1.
        clear_mon();
        i2c_start();
        wr(8'hD4, "t2_addr_ack");
        wr(8'h11, "t2_ptr_ack");
        wr(8'h01, "t2_d0"); wr(8'h23, "t2_d1"); wr(8'h45, "t2_d2"); wr(8'h67, "t2_d3");
        wr(8'h89, "t2_d4"); wr(8'hAB, "t2_d5"); wr(8'hCD, "t2_d6"); wr(8'hEF, "t2_d7");
        i2c_stop();
        check("t2_freq_ch1", frequency[127:64], 64'h0123456789ABCDEF);
        check("t2_freq_ch0", frequency[63:0], 64'h0);
        check("t2_update_cycles", upd_cnt, 1);
        check("t2_update_val", upd_or, 2'b10);
        check("t2_enable", enable, 2'b01);

        // Duty writes split across a repeated START commit together.
        clear_mon();
        i2c_start();
        wr(8'hD4, "t3_addr0"); wr(8'h09, "t3_ptr0"); wr(8'h80, "t3_d0"); wr(8'h00, "t3_d1");
        i2c_start();
        wr(8'hD4, "t3_addr1"); wr(8'h19, "t3_ptr1"); wr(8'h40, "t3_d2"); wr(8'h00, "t3_d3");
        check("t3_no_commit_on_rstart", upd_cnt, 0);
        i2c_stop();
        check("t3_update_cycles", upd_cnt, 1);
        check("t3_update_val", upd_or, 2'b11);
        check("t3_duty_ch0", duty_cycle[15:0], 16'h8000);
        check("t3_duty_ch1", duty_cycle[31:16], 16'h4000);
        check("t3_wave_kept", wave, 4'b0010);

        // Foreign address is ignored entirely.
        clear_mon();
        i2c_start();
        send_byte(8'hAA, ack);
        check("t4_addr_nack", ack, 1'b1);
        send_byte(8'h00, ack);
        send_byte(8'h07, ack);
        check("t4_data_nack", ack, 1'b1);
        i2c_stop();
        check("t4_oe_never", oe_seen, 1'b0);
        check("t4_busy_never", busy_seen, 1'b0);
        check("t4_no_update", upd_cnt, 0);
        check("t4_enable", enable, 2'b01);

        // Pointer wrap from an absent channel into channel 0.
        clear_mon();
        i2c_start();
        wr(8'hD4, "t5_addr"); wr(8'hFF, "t5_ptr"); wr(8'hAA, "t5_d_absent"); wr(8'h03, "t5_d_wrap");
        i2c_stop();
        check("t5_enable", enable, 2'b01);
        check("t5_wave", wave, 4'b0001);
        check("t5_update_cycles", upd_cnt, 1);
        check("t5_update_val", upd_or, 2'b01);
        check("t5_duty_kept", duty_cycle, 32'h4000_8000);

`ifdef I2C_NCO_READBACK_EN
        clear_mon();
        i2c_start();
        wr(8'hD4, "t6_addr_w"); wr(8'h11, "t6_ptr");
        i2c_start();
        wr(8'hD5, "t6_addr_r");
        recv_byte(rd, 1'b0);
        check("t6_rd0", rd, 8'h01);
        recv_byte(rd, 1'b0);
        check("t6_rd1", rd, 8'h23);
        recv_byte(rd, 1'b1);
        check("t6_rd2", rd, 8'h45);
        i2c_stop();
        check("t6_no_update", upd_cnt, 0);
        check("t6_busy_after_stop", busy, 1'b0);
`else
        clear_mon();
        i2c_start();
        send_byte(8'hD5, ack);
        check("t6_read_nack", ack, 1'b1);
        i2c_stop();
        check("t6_oe_never", oe_seen, 1'b0);
        check("t6_busy_never", busy_seen, 1'b0);
        check("t6_no_update", upd_cnt, 0);
`endif

        // Reset in the middle of a frequency write.
        i2c_start();
        wr(8'hD4, "t7_addr"); wr(8'h01, "t7_ptr");
        wr(8'h11, "t7_d0"); wr(8'h22, "t7_d1"); wr(8'h33, "t7_d2"); wr(8'h44, "t7_d3");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t7_enable", enable, 2'b00);
        check("t7_wave", wave, 4'h0);
        check("t7_freq", frequency, 128'h0);
        check("t7_duty", duty_cycle, 32'h0);
        check("t7_sda_oe", sda_oe, 1'b0);
        check("t7_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        clear_mon();
        i2c_stop();
        check("t7_no_update", upd_cnt, 0);
        check("t7_freq_after_stop", frequency, 128'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
